// File: rtl/carry_save_resolver_pkg.sv
`default_nettype none
// ============================================================================
// Module      : carry_save_resolver_pkg
// Description : Shared types and helpers for the carry-save resolver.
//               csr_state_t : controller states (IDLE / BUSY / DONE)
//               nchunk()    : number of CHUNK-bit slices covering WIDTH+2 bits
// Revision    : 1.0 - initial release
// ============================================================================
package carry_save_resolver_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } csr_state_t;

    // The result is WIDTH+2 bits wide, so that is what the chunks must cover.
    function automatic int nchunk(input int width, input int chunk);
        return (width + 2) / chunk;
    endfunction

endpackage : carry_save_resolver_pkg
`default_nettype wire

// File: rtl/carry_save_resolver_chunk.sv
`default_nettype none
// ============================================================================
// Module      : carry_save_resolver_chunk
// Description : Combinational CHUNK-bit adder slice with carry in / carry out.
//               Ports:
//                 a    in  CHUNK  addend slice
//                 b    in  CHUNK  addend slice
//                 cin  in  1      carry from the previous slice
//                 s    out CHUNK  sum slice
//                 cout out 1      carry into the next slice
// Revision    : 1.0 - initial release
// ============================================================================
module carry_save_resolver_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout
);

    logic [CHUNK:0] w_total;

    always_comb begin
        w_total = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
    end

    assign s    = w_total[CHUNK-1:0];
    assign cout = w_total[CHUNK];

endmodule : carry_save_resolver_chunk
`default_nettype wire

// File: rtl/carry_save_resolver.sv
`default_nettype none
// ============================================================================
// Module      : carry_save_resolver
// Description : Sequential carry-propagate stage turning a carry-save pair
//               into a binary value: out_result = in_sum + (in_carry << 1).
//               One CHUNK-bit slice is resolved per cycle through a single
//               time-multiplexed adder; the ripple carry lives in a flop.
//               Ports:
//                 clock      in   1        rising-edge clock
//                 reset      in   1        asynchronous, active-high
//                 in_valid   in   1        operand pair valid
//                 in_ready   out  1        block can accept an operand pair
//                 in_sum     in   WIDTH    CSA sum vector
//                 in_carry   in   WIDTH    CSA carry vector (weight 2^(i+1))
//                 out_valid  out  1        out_result valid
//                 out_ready  in   1        downstream accepts result
//                 out_result out  WIDTH+2  exact in_sum + 2*in_carry
// Revision    : 1.0 - initial release
// ============================================================================
module carry_save_resolver
    import carry_save_resolver_pkg::*;
#(
    parameter int WIDTH = 10,
    parameter int CHUNK = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_sum,
    input  logic [WIDTH-1:0]   in_carry,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH+1:0]   out_result
);

    localparam int RW     = WIDTH + 2;
    localparam int NCHUNK = nchunk(WIDTH, CHUNK);
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NCHUNK - 1);

    // Slices must tile the result exactly; anything else is a bad build.
    generate
        if ((RW % CHUNK) != 0) begin : g_bad_chunk
            $error("carry_save_resolver: (WIDTH+2) must be a multiple of CHUNK");
        end
    endgenerate

    csr_state_t         state_q,  state_d;
    logic [IDX_W-1:0]   idx_q,    idx_d;
    logic               cy_q,     cy_d;
    logic [RW-1:0]      a_q,      a_d;
    logic [RW-1:0]      b_q,      b_d;
    logic [RW-1:0]      result_q, result_d;

    logic [CHUNK-1:0]   w_a_sel;
    logic [CHUNK-1:0]   w_b_sel;
    logic [CHUNK-1:0]   w_s;
    logic               w_cout;

    // Pick the operand slice addressed by the chunk index.
    always_comb begin
        w_a_sel = '0;
        w_b_sel = '0;
        for (int k = 0; k < NCHUNK; k++) begin
            if (idx_q == IDX_W'(k)) begin
                w_a_sel = a_q[k*CHUNK +: CHUNK];
                w_b_sel = b_q[k*CHUNK +: CHUNK];
            end
        end
    end

    carry_save_resolver_chunk #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .a    (w_a_sel),
        .b    (w_b_sel),
        .cin  (cy_q),
        .s    (w_s),
        .cout (w_cout)
    );

    // Next-state and datapath control.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cy_d     = cy_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // The carry vector carries weight 2^(i+1): shift it left one.
                    a_d      = {2'b00, in_sum};
                    b_d      = {1'b0, in_carry, 1'b0};
                    result_d = '0;
                    idx_d    = '0;
                    cy_d     = 1'b0;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                for (int k = 0; k < NCHUNK; k++) begin
                    if (idx_q == IDX_W'(k)) begin
                        result_d[k*CHUNK +: CHUNK] = w_s;
                    end
                end
                cy_d  = w_cout;
                idx_d = idx_q + IDX_W'(1);
                if (idx_q == c_last_idx) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            cy_q     <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cy_q     <= cy_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign out_result = result_q;

    // 3*(2^WIDTH-1) always fits in WIDTH+2 bits, so the top slice never carries out.
    a_top_no_carry : assert property (
        @(posedge clock) disable iff (reset)
        ((state_q == BUSY) && (idx_q == c_last_idx)) |-> !w_cout
    );

endmodule : carry_save_resolver
`default_nettype wire
